// File: rtl/prefix_adder_pkg.sv
// Shared types and constant functions for the pipelined prefix adder.
// Partner index selects the lower (G,P) source of each black cell.
package prefix_adder_pkg;

  typedef enum int {
    KOGGE_STONE = 0,
    SKLANSKY    = 1
  } topo_e;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int num_stages(input int levels, input int k);
    return (levels + k - 1) / k;
  endfunction

  // -2 means the position passes straight through at this level
  function automatic int partner(input int i, input int lvl, input int topo);
    int h;
    h = 1 << (lvl - 1);
    if (topo == int'(KOGGE_STONE))
      return (i >= h) ? i - h : -2;
    return (((i / h) % 2) == 1) ? (i / h) * h - 1 : -2;
  endfunction

endpackage

// File: rtl/pipelined_prefix_adder_if.sv
// Operand/result handshake bundle for the pipelined prefix adder.
// Macro PREFIX_ADDER_OVF_EN adds the signed-overflow flag.
interface pipelined_prefix_adder_if
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic [TAG_W-1:0] out_tag;
`ifdef PREFIX_ADDER_OVF_EN
  logic             out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_tag, out_ovf
  );
  modport master (
    output in_valid, in_a, in_b, in_cin, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_tag, out_ovf
  );
`else
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_tag
  );
  modport master (
    output in_valid, in_a, in_b, in_cin, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_tag
  );
`endif
endinterface

// File: rtl/prefix_black_cell.sv
// Prefix combine operator: high group absorbs the adjacent low group.
module prefix_black_cell
  import prefix_adder_pkg::*;
(
  input  gp_t i_hi,
  input  gp_t i_lo,
  output gp_t o_gp
);
  assign o_gp.g = i_hi.g | (i_hi.p & i_lo.g);
  assign o_gp.p = i_hi.p & i_lo.p;
endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone/Sklansky adder with valid/ready and in-order tag.
// Macro PREFIX_ADDER_OVF_EN adds the registered out_ovf flag.
module pipelined_prefix_adder
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int LVL_PER_STAGE = 2,
  parameter int TOPOLOGY      = 0,
  parameter int TAG_W         = 4
) (
  input logic clk,
  input logic rst_n,
  pipelined_prefix_adder_if.slave bus
);
  localparam int LEVELS = clog2(WIDTH);
  localparam int K      = LVL_PER_STAGE;
  localparam int S      = num_stages(LEVELS, K);

  if (TOPOLOGY != int'(KOGGE_STONE) &&
      TOPOLOGY != int'(SKLANSKY)) begin : g_bad_topo
    $error("pipelined_prefix_adder: TOPOLOGY must be 0 or 1");
  end

  logic [S-1:0]     r_v;
  logic [S-1:0]     w_en;
  logic [S-1:0]     w_sv;
  logic [WIDTH-1:0] w_g0;
  logic [WIDTH-1:0] w_p0;
  logic [WIDTH-1:0] w_lp0;
  logic             w_lcin;
  logic [TAG_W-1:0] w_ltag;
  logic [WIDTH-1:0] w_c;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic [TAG_W-1:0] r_tag;
`ifdef PREFIX_ADDER_OVF_EN
  logic             r_ovf;
`endif

  assign w_g0 = bus.in_a & bus.in_b;
  assign w_p0 = bus.in_a ^ bus.in_b;

  // Ready ripples back from the consumer; empty stages always load
  always_comb begin
    w_en = '0;
    w_sv = '0;
    w_sv[0] = bus.in_valid;
    for (int s = 1; s < S; s++) w_sv[s] = r_v[s-1];
    w_en[S-1] = !r_v[S-1] | bus.out_ready;
    for (int s = S - 2; s >= 0; s--) w_en[s] = !r_v[s] | w_en[s+1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
    end else begin
      for (int s = 0; s < S; s++)
        if (w_en[s]) r_v[s] <= w_sv[s];
    end
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    logic [WIDTH-1:0] w_ig;
    logic [WIDTH-1:0] w_ip;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;

    if (l == 1) begin : g_in
      assign w_ig = w_g0;
      assign w_ip = w_p0;
    end else if (((l - 1) % K) == 0) begin : g_in
      assign w_ig = g_stg[(l-1)/K-1].r_g;
      assign w_ip = g_stg[(l-1)/K-1].r_p;
    end else begin : g_in
      assign w_ig = g_lvl[l-1].w_g;
      assign w_ip = g_lvl[l-1].w_p;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      localparam int PT = partner(i, l, TOPOLOGY);
      if (PT >= 0) begin : g_bc
        gp_t w_o;
        prefix_black_cell u_bc (
          .i_hi ({w_ig[i], w_ip[i]}),
          .i_lo ({w_ig[PT], w_ip[PT]}),
          .o_gp (w_o)
        );
        assign w_g[i] = w_o.g;
        assign w_p[i] = w_o.p;
      end else begin : g_pass
        assign w_g[i] = w_ig[i];
        assign w_p[i] = w_ip[i];
      end
    end
  end

  for (genvar s = 0; s < S - 1; s++) begin : g_stg
    logic [WIDTH-1:0] r_g;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_p0;
    logic             r_cin;
    logic [TAG_W-1:0] r_tag;
    logic [WIDTH-1:0] w_p0i;
    logic             w_cini;
    logic [TAG_W-1:0] w_tagi;

    if (s == 0) begin : g_src
      assign w_p0i  = w_p0;
      assign w_cini = bus.in_cin;
      assign w_tagi = bus.in_tag;
    end else begin : g_src
      assign w_p0i  = g_stg[s-1].r_p0;
      assign w_cini = g_stg[s-1].r_cin;
      assign w_tagi = g_stg[s-1].r_tag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_g   <= '0;
        r_p   <= '0;
        r_p0  <= '0;
        r_cin <= 1'b0;
        r_tag <= '0;
      end else if (w_en[s] && w_sv[s]) begin
        r_g   <= g_lvl[(s+1)*K].w_g;
        r_p   <= g_lvl[(s+1)*K].w_p;
        r_p0  <= w_p0i;
        r_cin <= w_cini;
        r_tag <= w_tagi;
      end
    end
  end

  if (S == 1) begin : g_last
    assign w_lp0  = w_p0;
    assign w_lcin = bus.in_cin;
    assign w_ltag = bus.in_tag;
  end else begin : g_last
    assign w_lp0  = g_stg[S-2].r_p0;
    assign w_lcin = g_stg[S-2].r_cin;
    assign w_ltag = g_stg[S-2].r_tag;
  end

  // Carry-in enters as position -1 (G=cin, P=0) via one final gray cell
  assign w_c = g_lvl[LEVELS].w_g |
               (g_lvl[LEVELS].w_p & {WIDTH{w_lcin}});
  assign w_sum = w_lp0 ^ {w_c[WIDTH-2:0], w_lcin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_tag  <= '0;
`ifdef PREFIX_ADDER_OVF_EN
      r_ovf  <= 1'b0;
`endif
    end else if (w_en[S-1] && w_sv[S-1]) begin
      r_sum  <= w_sum;
      r_cout <= w_c[WIDTH-1];
      r_tag  <= w_ltag;
`ifdef PREFIX_ADDER_OVF_EN
      r_ovf  <= w_c[WIDTH-1] ^ w_c[WIDTH-2];
`endif
    end
  end

  assign bus.in_ready  = w_en[0];
  assign bus.out_valid = r_v[S-1];
  assign bus.out_sum   = r_sum;
  assign bus.out_cout  = r_cout;
  assign bus.out_tag   = r_tag;
`ifdef PREFIX_ADDER_OVF_EN
  assign bus.out_ovf   = r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Bench: Kogge-Stone and Sklansky instances (WIDTH=32, K=2, S=3)
// driven in lockstep and checked against a queue-based scoreboard.
module tb_pipelined_prefix_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic [3:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [3:0]  tag;
  logic        out_ready;

  int   checks = 0;
  int   errors = 0;
  int   acc_cnt = 0;
  int   cyc = 0;
  bit   rnd_rdy = 1'b0;
  bit   hold [2];
  exp_t prev [2];
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t obs0;
  exp_t obs1;
  logic ovf0;
  logic ovf1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  pipelined_prefix_adder_if #(.WIDTH(32), .TAG_W(4)) bus0 ();
  pipelined_prefix_adder_if #(.WIDTH(32), .TAG_W(4)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_a      = a;
  assign bus0.in_b      = b;
  assign bus0.in_cin    = cin;
  assign bus0.in_tag    = tag;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_a      = a;
  assign bus1.in_b      = b;
  assign bus1.in_cin    = cin;
  assign bus1.in_tag    = tag;
  assign bus1.out_ready = out_ready;

  pipelined_prefix_adder #(
    .WIDTH(32), .LVL_PER_STAGE(2), .TOPOLOGY(0), .TAG_W(4)
  ) u_ks (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  pipelined_prefix_adder #(
    .WIDTH(32), .LVL_PER_STAGE(2), .TOPOLOGY(1), .TAG_W(4)
  ) u_sk (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

`ifdef PREFIX_ADDER_OVF_EN
  assign ovf0 = bus0.out_ovf;
  assign ovf1 = bus1.out_ovf;
`else
  assign ovf0 = 1'b0;
  assign ovf1 = 1'b0;
`endif

  assign obs0 = {bus0.out_sum, bus0.out_cout, ovf0, bus0.out_tag};
  assign obs1 = {bus1.out_sum, bus1.out_cout, ovf1, bus1.out_tag};

  task automatic chk(input string nm, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic c, input logic [3:0] t);
    logic [32:0] r;
    exp_t e;
    r = {1'b0, x} + {1'b0, y} + {32'd0, c};
    e.sum  = r[31:0];
    e.cout = r[32];
    e.tag  = t;
`ifdef PREFIX_ADDER_OVF_EN
    e.ovf  = (x[31] == y[31]) && (r[31] != x[31]);
`else
    e.ovf  = 1'b0;
`endif
    return e;
  endfunction

  task automatic mon(input int k, input logic v, input exp_t o);
    exp_t e;
    if (hold[k]) chk("hold_stable", {v, o}, {1'b1, prev[k]});
    if (v && out_ready) begin
      if (k == 0) begin
        chk("sb_nonempty_ks", 64'(q0.size() != 0), 64'd1);
        if (q0.size() != 0) begin
          e = q0.pop_front();
          chk("result_ks", o, e);
        end
      end else begin
        chk("sb_nonempty_sk", 64'(q1.size() != 0), 64'd1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          chk("result_sk", o, e);
        end
      end
    end
    hold[k] = v && !out_ready;
    prev[k] = o;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_match", 64'(bus1.in_ready), 64'(bus0.in_ready));
      if (in_valid && bus0.in_ready) begin
        q0.push_back(model(a, b, cin, tag));
        q1.push_back(model(a, b, cin, tag));
        acc_cnt++;
      end
      mon(0, bus0.out_valid, obs0);
      mon(1, bus1.out_valid, obs1);
    end
  end

  always @(posedge clk) begin
    #2;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [31:0] ia, input logic [31:0] ib,
                      input logic ic, input logic [3:0] it);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    a = ia;
    b = ib;
    cin = ic;
    tag = it;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = bus0.in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain_ks", 64'(q0.size()), 64'd0);
    chk("drain_sk", 64'(q1.size()), 64'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int tg;
    hold[0] = 1'b0;
    hold[1] = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    tag = '0;
    out_ready = 1'b1;
    tg = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus0.out_valid), 64'd0);
    chk("rst_out_sum", 64'(bus0.out_sum), 64'd0);
    chk("rst_out_cout", 64'(bus1.out_cout), 64'd0);
    chk("rst_out_tag", 64'(bus1.out_tag), 64'd0);
    rst_n = 1'b1;
    chk("rst_in_ready", 64'(bus0.in_ready), 64'd1);

    // Directed carry-out with exact 3-cycle latency
    @(posedge clk);
    #1;
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'd3);
    @(posedge clk);
    #1;
    chk("lat_not_early", 64'(bus0.out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_valid_ks", 64'(bus0.out_valid), 64'd1);
    chk("lat_valid_sk", 64'(bus1.out_valid), 64'd1);
    chk("wrap_sum", 64'(bus0.out_sum), 64'd0);
    chk("wrap_cout", 64'(bus0.out_cout), 64'd1);
    chk("wrap_tag", 64'(bus1.out_tag), 64'd3);
    drain();

    // Carry-in ripples into the sign bit
    send(32'h7FFF_FFFF, 32'h0, 1'b1, 4'd5);
    repeat (2) @(posedge clk);
    #1;
    chk("cin_sum", 64'(bus1.out_sum), 64'h8000_0000);
    chk("cin_cout", 64'(bus1.out_cout), 64'd0);
`ifdef PREFIX_ADDER_OVF_EN
    chk("cin_ovf", 64'(bus0.out_ovf), 64'd1);
`endif
    drain();

    // Full throughput: every beat accepted on its first cycle
    start = cyc;
    for (int i = 0; i < 1000; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 4'(tg));
      tg++;
    end
    chk("throughput", 64'(cyc - start), 64'd1000);
    drain();

    // Backpressure: pipeline fills with exactly 3 beats
    out_ready = 1'b0;
    start = acc_cnt;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom;
      cin = 1'($urandom_range(0, 1));
      tag = 4'(tg);
      tg++;
      @(posedge clk);
      #1;
    end
    chk("bp_accepts", 64'(acc_cnt - start), 64'd3);
    chk("bp_in_ready", 64'(bus0.in_ready), 64'd0);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Random valid and ready duty
    rnd_rdy = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 4'(tg));
      tg++;
    end
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 4'd9);
    send(32'hFFFF_0000, 32'h0001_0000, 1'b1, 4'd10);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_valid", 64'(bus0.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_ks", 64'(bus0.out_valid), 64'd0);
    chk("mid_rst_valid_sk", 64'(bus1.out_valid), 64'd0);
    chk("mid_rst_sum", 64'(bus0.out_sum), 64'd0);
    chk("mid_rst_cout", 64'(bus1.out_cout), 64'd0);
    chk("mid_rst_tag", 64'(bus0.out_tag), 64'd0);
    q0.delete();
    q1.delete();
    hold[0] = 1'b0;
    hold[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("post_rst_ready", 64'(bus0.in_ready), 64'd1);
    chk("post_rst_valid", 64'(bus1.out_valid), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 4'(tg));
      tg++;
    end
    drain();
    repeat (5) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
